// File: rtl/alu_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_collector
// Purpose  : Upstream feeder for the ALU core. Collects OPA/OPB beats (joint
//            or split) into complete operations, buffers them in a small FIFO
//            and drives the registered ALU input bus at most one operation per
//            clock-enabled cycle. A half-collected operation that does not
//            complete within TIMEOUT enabled cycles is issued as a partial
//            operation so the ALU raises ERR.
// Ports    : clk, RST (sync, active low), CE (shared clock enable)
//            in_valid/in_ready/in_sel/in_opa/in_opb/in_cin/in_mode/in_cmd :
//              upstream beat stream
//            OPA/OPB/Cin/mode/CMD/inp_valid : registered ALU input bus
//            fifo_count, pending, timeout_pulse : status
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_collector #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_sel,
  input  logic [W-1:0]               in_opa,
  input  logic [W-1:0]               in_opb,
  input  logic                       in_cin,
  input  logic                       in_mode,
  input  logic [N-1:0]               in_cmd,
  output logic [W-1:0]               OPA,
  output logic [W-1:0]               OPB,
  output logic                       Cin,
  output logic                       mode,
  output logic [N-1:0]               CMD,
  output logic [1:0]                 inp_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       pending,
  output logic                       timeout_pulse
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);
  localparam int c_TW = $clog2(TIMEOUT+1);
  localparam int c_EW = 2*W + 2 + N + 2;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
  localparam logic [c_TW-1:0] c_TIMEOUT   = c_TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,   // OPA held, waiting for OPB
    S_WAIT_A = 2'd2    // OPB held, waiting for OPA
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_TW-1:0]   r_cnt, w_cnt_nxt;
  logic [W-1:0]      r_hold_opr;
  logic              r_hold_cin, r_hold_mode;
  logic [N-1:0]      r_hold_cmd;

  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wptr, r_rptr;
  logic [c_CW-1:0]   r_count;

  logic [W-1:0]      r_opa, r_opb;
  logic              r_cin, r_mode, r_pulse;
  logic [N-1:0]      r_cmd;
  logic [1:0]        r_inp_valid;

  logic              w_full, w_empty, w_pop, w_ready, w_accept, w_expire;
  logic              w_push, w_pulse, w_latch;
  logic [c_EW-1:0]   w_push_data, w_partial, w_pair;
  logic [1:0]        w_match, w_same;

  assign w_full   = (r_count == c_DEPTH_CNT);
  assign w_empty  = (r_count == '0);
  assign w_pop    = CE && !w_empty;
  // A joint beat cannot be absorbed while a half is held; it is stalled so
  // the held half can be flushed first.
  assign w_ready  = RST && !w_full && !((r_state != S_IDLE) && (in_sel == 2'b11));
  assign w_accept = in_valid && w_ready;
  // Saturated counter means expiry already happened while the FIFO was full.
  assign w_expire = (r_cnt == c_TIMEOUT) || (CE && (r_cnt == c_TIMEOUT - 1'b1));

  // Operand that completes the held half, and the one that replaces it.
  assign w_match  = (r_state == S_WAIT_B) ? 2'b10 : 2'b01;
  assign w_same   = (r_state == S_WAIT_B) ? 2'b01 : 2'b10;

  assign w_partial = (r_state == S_WAIT_A)
                   ? {{W{1'b0}}, r_hold_opr, r_hold_cin, r_hold_mode, r_hold_cmd, 2'b10}
                   : {r_hold_opr, {W{1'b0}}, r_hold_cin, r_hold_mode, r_hold_cmd, 2'b01};
  // Control fields always come from the first beat of a pair.
  assign w_pair    = (r_state == S_WAIT_A)
                   ? {in_opa, r_hold_opr, r_hold_cin, r_hold_mode, r_hold_cmd, 2'b11}
                   : {r_hold_opr, in_opb, r_hold_cin, r_hold_mode, r_hold_cmd, 2'b11};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_data = '0;
    w_pulse     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (in_sel)
            2'b11: begin
              w_push      = 1'b1;
              w_push_data = {in_opa, in_opb, in_cin, in_mode, in_cmd, 2'b11};
            end
            2'b01: begin
              w_latch     = 1'b1;
              w_state_nxt = S_WAIT_B;
              w_cnt_nxt   = '0;
            end
            2'b10: begin
              w_latch     = 1'b1;
              w_state_nxt = S_WAIT_A;
              w_cnt_nxt   = '0;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_B, S_WAIT_A: begin
        if (w_accept && (in_sel == w_match)) begin
          w_push      = 1'b1;
          w_push_data = w_pair;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_accept && (in_sel == w_same)) begin
          // Flush the old half and start over with the new beat.
          w_push      = 1'b1;
          w_push_data = w_partial;
          w_pulse     = 1'b1;
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
        end else if (((in_valid && (in_sel == 2'b11)) || w_expire) && !w_full) begin
          w_push      = 1'b1;
          w_push_data = w_partial;
          w_pulse     = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_expire) begin
          w_cnt_nxt   = c_TIMEOUT;
        end else if (CE) begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold_opr  <= '0;
      r_hold_cin  <= 1'b0;
      r_hold_mode <= 1'b0;
      r_hold_cmd  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_cin       <= 1'b0;
      r_mode      <= 1'b0;
      r_cmd       <= '0;
      r_inp_valid <= 2'b00;
      r_pulse     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse;
      if (w_latch) begin
        r_hold_opr  <= (in_sel == 2'b01) ? in_opa : in_opb;
        r_hold_cin  <= in_cin;
        r_hold_mode <= in_mode;
        r_hold_cmd  <= in_cmd;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (CE) begin
        if (!w_empty) {r_opa, r_opb, r_cin, r_mode, r_cmd, r_inp_valid} <= r_mem[r_rptr];
        else          r_inp_valid <= 2'b00;
      end
    end
  end

  assign in_ready      = w_ready;
  assign OPA           = r_opa;
  assign OPB           = r_opb;
  assign Cin           = r_cin;
  assign mode          = r_mode;
  assign CMD           = r_cmd;
  assign inp_valid     = r_inp_valid;
  assign fifo_count    = r_count;
  assign pending       = (r_state != S_IDLE);
  assign timeout_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_collector
// Purpose  : Self-checking bench for alu_operand_collector. Expected ALU
//            operations are queued as beats are driven and compared against
//            every issue seen on the ALU bus; scenario tasks add direct checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_collector;

  logic       clk = 1'b0;
  logic       RST, CE, in_valid, in_ready, in_cin, in_mode;
  logic [1:0] in_sel;
  logic [7:0] in_opa, in_opb;
  logic [3:0] in_cmd;
  logic [7:0] OPA, OPB;
  logic       Cin, mode, pending, timeout_pulse;
  logic [3:0] CMD;
  logic [1:0] inp_valid;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    logic [3:0] cmd;
    logic [1:0] mask;
  } op_t;

  op_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  alu_operand_collector #(.W(8), .N(4), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .RST(RST), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_opa(in_opa), .in_opb(in_opb), .in_cin(in_cin), .in_mode(in_mode), .in_cmd(in_cmd),
    .OPA(OPA), .OPB(OPB), .Cin(Cin), .mode(mode), .CMD(CMD), .inp_valid(inp_valid),
    .fifo_count(fifo_count), .pending(pending), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(input logic [7:0] a, input logic [7:0] b, input logic cin,
                             input logic md, input logic [3:0] cmd, input logic [1:0] mask);
    op_t o;
    o.a = a; o.b = b; o.cin = cin; o.mode = md; o.cmd = cmd; o.mask = mask;
    return o;
  endfunction

  // Scoreboard: every operation issued on a CE edge is checked against the queue.
  // Operand fields are only compared where the mask says they are valid.
  always begin : sb_monitor
    logic ce_s;
    op_t  e;
    @(posedge clk);
    ce_s = CE && RST;
    #2;
    if (ce_s && (inp_valid !== 2'b00)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL issue_unexpected: got mask=%b OPA=%h OPB=%h CMD=%h, expected no issue",
                 inp_valid, OPA, OPB, CMD);
      end else begin
        e = exp_q.pop_front();
        if ((inp_valid !== e.mask) || (e.mask[0] && (OPA !== e.a)) || (e.mask[1] && (OPB !== e.b)) ||
            (Cin !== e.cin) || (mode !== e.mode) || (CMD !== e.cmd)) begin
          miscompares++;
          $display("FAIL issue_scoreboard: got mask=%b OPA=%h OPB=%h Cin=%b mode=%b CMD=%h, expected mask=%b OPA=%h OPB=%h Cin=%b mode=%b CMD=%h",
                   inp_valid, OPA, OPB, Cin, mode, CMD, e.mask, e.a, e.b, e.cin, e.mode, e.cmd);
        end
      end
    end
  end

  // Presents one beat and holds it until accepted (bounded); returns 1ns after
  // the accepting edge with in_valid dropped.
  task automatic send_beat(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic md, input logic [3:0] cmd);
    int n;
    @(negedge clk);
    in_sel = sel; in_opa = a; in_opb = b; in_cin = cin; in_mode = md; in_cmd = cmd;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; CE = 1'b1; in_valid = 1'b1; in_sel = 2'b11;
    in_opa = 8'h55; in_opb = 8'h66; in_cin = 1'b1; in_mode = 1'b1; in_cmd = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready);
    end
    vectors++;
    if ({OPA, OPB, Cin, mode, CMD, inp_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got OPA=%h OPB=%h Cin=%b mode=%b CMD=%h inp_valid=%b, expected all 0",
               OPA, OPB, Cin, mode, CMD, inp_valid);
    end
    vectors++;
    if ({fifo_count, pending, timeout_pulse} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got fifo_count=%0d pending=%b timeout_pulse=%b, expected 0 0 0",
               fifo_count, pending, timeout_pulse);
    end
    @(negedge clk);
    in_valid = 1'b0; RST = 1'b1;
  endtask

  task automatic test_full_pair();
    exp_q.push_back(mk(8'h12, 8'h34, 1'b0, 1'b1, 4'h0, 2'b11));
    send_beat(2'b11, 8'h12, 8'h34, 1'b0, 1'b1, 4'h0);
    vectors++;
    if (fifo_count !== 3'd1 || inp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL pair_queued: got fifo_count=%0d inp_valid=%b, expected 1 00", fifo_count, inp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (OPA !== 8'h12 || OPB !== 8'h34 || CMD !== 4'h0 || inp_valid !== 2'b11) begin
      miscompares++;
      $display("FAIL pair_issue: got OPA=%h OPB=%h CMD=%h inp_valid=%b, expected 12 34 0 11",
               OPA, OPB, CMD, inp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (inp_valid !== 2'b00) begin
      miscompares++; $display("FAIL pair_idle_after: got inp_valid=%b, expected 00", inp_valid);
    end
  endtask

  task automatic test_split_pair();
    exp_q.push_back(mk(8'hF0, 8'h0F, 1'b0, 1'b1, 4'h3, 2'b11));
    send_beat(2'b01, 8'hF0, 8'h99, 1'b0, 1'b1, 4'h3);
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++; $display("FAIL split_pending_set: got %b, expected 1", pending);
    end
    repeat (2) @(posedge clk);
    send_beat(2'b10, 8'h77, 8'h0F, 1'b1, 1'b0, 4'h7);
    vectors++;
    if (pending !== 1'b0 || timeout_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL split_pending_clear: got pending=%b timeout_pulse=%b, expected 0 0", pending, timeout_pulse);
    end
    @(posedge clk); #1;
    vectors++;
    if (inp_valid !== 2'b11 || CMD !== 4'h3 || OPA !== 8'hF0 || OPB !== 8'h0F) begin
      miscompares++;
      $display("FAIL split_issue: got inp_valid=%b CMD=%h OPA=%h OPB=%h, expected 11 3 F0 0F",
               inp_valid, CMD, OPA, OPB);
    end
  endtask

  task automatic test_timeout();
    int early;
    exp_q.push_back(mk(8'hAA, 8'h00, 1'b1, 1'b1, 4'h5, 2'b01));
    send_beat(2'b01, 8'hAA, 8'h00, 1'b1, 1'b1, 4'h5);
    early = (timeout_pulse !== 1'b0) ? 1 : 0;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      if (timeout_pulse !== 1'b0) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++; $display("FAIL timeout_early: pulse seen on %0d cycles before expiry, expected 0", early);
    end
    @(posedge clk); #1;
    vectors++;
    if (timeout_pulse !== 1'b1 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got pulse=%b pending=%b, expected 1 0", timeout_pulse, pending);
    end
    @(posedge clk); #1;
    vectors++;
    if (timeout_pulse !== 1'b0 || inp_valid !== 2'b01 || OPA !== 8'hAA) begin
      miscompares++;
      $display("FAIL timeout_issue: got pulse=%b inp_valid=%b OPA=%h, expected 0 01 AA",
               timeout_pulse, inp_valid, OPA);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    CE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(8'h10 + 8'(i), 8'h80 + 8'(i), i[0], 1'b1, 4'(i), 2'b11));
      send_beat(2'b11, 8'h10 + 8'(i), 8'h80 + 8'(i), i[0], 1'b1, 4'(i));
    end
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++; $display("FAIL full_count: got %0d, expected 4", fifo_count);
    end
    @(negedge clk);
    in_sel = 2'b11; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_in_ready: got %b, expected 0", in_ready);
    end
    in_valid = 1'b0;
    CE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (inp_valid !== 2'b11 || OPA !== 8'h10 + 8'(k)) begin
        miscompares++;
        $display("FAIL drain_order[%0d]: got inp_valid=%b OPA=%h, expected 11 %h", k, inp_valid, OPA, 8'h10 + 8'(k));
      end
    end
    vectors++;
    if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_done: got fifo_count=%0d in_ready=%b, expected 0 1", fifo_count, in_ready);
    end
  endtask

  task automatic test_collision_reset();
    int stray;
    exp_q.push_back(mk(8'h5A, 8'h00, 1'b0, 1'b1, 4'h2, 2'b01));
    send_beat(2'b01, 8'h5A, 8'h00, 1'b0, 1'b1, 4'h2);
    @(negedge clk);
    in_sel = 2'b11; in_opa = 8'h11; in_opb = 8'h22; in_cin = 1'b1; in_mode = 1'b0; in_cmd = 4'h9;
    in_valid = 1'b1;
    exp_q.push_back(mk(8'h11, 8'h22, 1'b1, 1'b0, 4'h9, 2'b11));
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL collide_stall: got in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (timeout_pulse !== 1'b1 || pending !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_flush: got pulse=%b pending=%b in_ready=%b, expected 1 0 1",
               timeout_pulse, pending, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (inp_valid !== 2'b01 || OPA !== 8'h5A || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL collide_partial: got inp_valid=%b OPA=%h fifo_count=%0d, expected 01 5A 1",
               inp_valid, OPA, fifo_count);
    end
    @(posedge clk); #1;
    vectors++;
    if (inp_valid !== 2'b11 || OPA !== 8'h11 || OPB !== 8'h22) begin
      miscompares++;
      $display("FAIL collide_beat: got inp_valid=%b OPA=%h OPB=%h, expected 11 11 22", inp_valid, OPA, OPB);
    end
    // Queue two operations plus a pending half, then reset: all discarded.
    @(negedge clk);
    CE = 1'b0;
    send_beat(2'b11, 8'h01, 8'h02, 1'b0, 1'b0, 4'h1);
    send_beat(2'b11, 8'h03, 8'h04, 1'b0, 1'b0, 4'h2);
    send_beat(2'b01, 8'h05, 8'h00, 1'b0, 1'b0, 4'h3);
    vectors++;
    if (fifo_count !== 3'd2 || pending !== 1'b1) begin
      miscompares++;
      $display("FAIL prereset_state: got fifo_count=%0d pending=%b, expected 2 1", fifo_count, pending);
    end
    @(negedge clk); RST = 1'b0;
    @(negedge clk); RST = 1'b1;
    vectors++;
    if (fifo_count !== 3'd0 || pending !== 1'b0 || inp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL midreset_clear: got fifo_count=%0d pending=%b inp_valid=%b, expected 0 0 00",
               fifo_count, pending, inp_valid);
    end
    CE = 1'b1;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (inp_valid !== 2'b00) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL midreset_no_issue: got %0d issues after reset, expected 0", stray);
    end
  endtask

  initial begin
    RST = 1'b0; CE = 1'b1; in_valid = 1'b0; in_sel = 2'b00;
    in_opa = '0; in_opb = '0; in_cin = 1'b0; in_mode = 1'b0; in_cmd = '0;
    test_reset();
    test_full_pair();
    test_split_pair();
    test_timeout();
    test_backpressure();
    test_collision_reset();
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d expected operations never issued, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Upstream feeder for the ALU core.
- Accepts operand beats on a valid/ready stream. OPA and OPB may arrive together or in separate beats.
- Pairs separate beats into one ALU operation and buffers finished operations in a small FIFO.
- Drives the ALU input bus (OPA, OPB, Cin, mode, CMD, inp_valid) at most one operation per clock-enabled cycle.
- When a pair does not complete within TIMEOUT cycles, it issues the partial operation so the ALU raises ERR.

Parameters:
- W, 8, operand width.
- N, 4, CMD width.
- DEPTH, 4, operation FIFO entries (power of two, at least 2).
- TIMEOUT, 16, clock-enabled cycles to wait for the missing operand.

Ports:
- clk  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-low reset.
- CE  in  1  clock enable shared with the ALU; gates pop and timeout counting.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready at posedge.
- in_sel  in  2  01 = OPA beat, 10 = OPB beat, 11 = both; 00 is illegal (accepted, ignored).
- in_opa  in  W  operand A.
- in_opb  in  W  operand B.
- in_cin  in  1  carry in.
- in_mode  in  1  1 = arithmetic, 0 = logical.
- in_cmd  in  N  command.
- OPA, OPB  out  W  ALU operands (registered).
- Cin, mode  out  1  registered.
- CMD  out  N  registered.
- inp_valid  out  2  00 = no operation this cycle; else operand mask of the issued operation.
- fifo_count  out  $clog2(DEPTH+1)  occupied FIFO entries.
- pending  out  1  a half-collected operation is held.
- timeout_pulse  out  1  one-cycle pulse when a partial operation is forced out.

Behaviour:
- Reset (RST==0 at posedge):
  - state IDLE, FIFO emptied, timeout counter 0.
  - All outputs 0; in_ready 0 while RST==0.
  - Reset mid-operation discards the pending half and all queued operations.
- Collector states:
  - IDLE: nothing held.
  - WAIT_B: OPA held.
  - WAIT_A: OPB held.
- Ready rule: in_ready = !full && !(state!=IDLE && in_sel==11). in_ready may depend on in_sel.
- IDLE:
  - sel 11: push {opa, opb, cin, mode, cmd, mask 11}; stay IDLE.
  - sel 01 / 10: latch operand plus cin/mode/cmd; go to WAIT_B / WAIT_A; counter cleared.
- WAIT_B, beat with sel 10:
  - push the pair with mask 11; go IDLE.
  - cin/mode/cmd come from the first beat; second-beat values are ignored.
- WAIT_B, beat with sel 01:
  - push the held partial with mask 01 and raise timeout_pulse.
  - the new beat becomes the pending half; counter restarts.
- WAIT_A: symmetric to WAIT_B.
- WAIT state, in_valid with sel 11: beat not accepted that cycle; the held partial is pushed (mask 01/10, timeout_pulse); go IDLE; the beat is accepted on a later cycle.
- Timeout:
  - counter increments in WAIT states on cycles with CE==1 and no completing beat.
  - when it reaches TIMEOUT, push the partial, raise timeout_pulse, go IDLE.
  - if the FIFO is full, the counter saturates at TIMEOUT and the push happens on the first cycle with space.
  - a completing beat in the same cycle as expiry wins: pair issued with mask 11, no pulse.
- FIFO:
  - at most one push per cycle; push is independent of CE.
  - push allowed only when not full; no pass-through when full, even with a simultaneous pop.
  - pointers wrap modulo DEPTH.
- Issue:
  - on posedge with CE==1 and FIFO non-empty: pop the head into the output registers; inp_valid = entry mask.
  - on posedge with CE==1 and FIFO empty: inp_valid = 00; other outputs hold.
  - CE==0: output registers and FIFO head hold; inp_valid holds its value.
- Latency: a sel=11 beat accepted at edge t into an empty FIFO appears on the ALU bus after edge t+1 (CE high). Throughput is one operation per CE cycle.
- fifo_count and pending are registered state, updated on the same edge as the push or pop.

Test Plan:
- Reset: hold RST=0 for 2 cycles with in_valid=1 → all outputs 0, in_ready=0, fifo_count=0.
- Full pair: CE=1; beat sel=11, OPA=0x12, OPB=0x34, cmd=0, mode=1 → one cycle later OPA=0x12, OPB=0x34, CMD=0, inp_valid=11. Next cycle inp_valid=00.
- Split pair: sel=01 OPA=0xF0, cmd=3; 3 cycles later sel=10 OPB=0x0F, cmd=7 → single issue with inp_valid=11, CMD=3. pending goes 1 then 0.
- Timeout: sel=01 OPA=0xAA, then no beats, CE=1 → after 16 cycles timeout_pulse=1 for one cycle; next cycle inp_valid=01, OPA=0xAA.
- Backpressure and full FIFO: CE=0; 4 sel=11 beats → fifo_count=4, in_ready=0. Raise CE → 4 issues in input order on consecutive cycles, then in_ready=1.
- Collision and mid-reset: in WAIT_B send sel=11 → in_ready=0 that cycle, partial issued with mask 01, beat accepted the next cycle. Then assert RST with 2 entries queued → fifo_count=0, pending=0, nothing issued.
